// File: rtl/countdown_timer_pkg.sv
// Shared timer definitions used by the up/down counters and the display logic.
package countdown_timer_pkg;

  localparam int TIME_W      = 6;
  localparam int MAX_VAL_DEF = 59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_e;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss down-counter with load/start/pause control and a one-cycle done pulse at 00:00.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int MAX_VAL       = MAX_VAL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TIME_W-1:0] load_min,
  input  logic [TIME_W-1:0] load_sec,
  input  logic              start,
  input  logic              pause,
  output logic [TIME_W-1:0] minute,
  output logic [TIME_W-1:0] second,
  output logic              running,
  output logic              done
);

  localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_VAL);

  timer_state_e      state, state_nxt;
  logic [TIME_W-1:0] min_nxt, sec_nxt;
  logic              done_nxt;
  logic              pre_en, pre_clr, tick;

  function automatic logic [TIME_W-1:0] sat_time(input logic [TIME_W-1:0] v);
    return (v > MAX_T) ? MAX_T : v;
  endfunction

  // Counting stops on the edge a load or pause is seen, so a pause that
  // lands on a tick edge leaves the prescaler parked on its last count.
  assign pre_en = (state == RUN) && !load && !pause;

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    min_nxt   = minute;
    sec_nxt   = second;
    done_nxt  = 1'b0;
    pre_clr   = 1'b0;
    if (load) begin
      min_nxt   = sat_time(load_min);
      sec_nxt   = sat_time(load_sec);
      state_nxt = IDLE;
      pre_clr   = 1'b1;
    end else if (pause) begin
      if (state == RUN) state_nxt = PAUSED;
    end else if (start && (state == IDLE)) begin
      if ((minute != '0) || (second != '0)) begin
        state_nxt = RUN;
        pre_clr   = 1'b1;
      end
    end else if (start && (state == PAUSED)) begin
      state_nxt = RUN;
    end else if ((state == RUN) && tick) begin
      if (second != '0) begin
        sec_nxt = second - 1'b1;
      end else if (minute != '0) begin
        sec_nxt = MAX_T;
        min_nxt = minute - 1'b1;
      end
      if ((minute == '0) && (second == TIME_W'(1))) begin
        state_nxt = EXPIRED;
        done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      minute  <= '0;
      second  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      minute  <= min_nxt;
      second  <= sec_nxt;
      running <= (state_nxt == RUN);
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: a 4-cycle-prescaler instance and a 1-cycle instance share one stimulus.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, start, pause;
  logic [5:0] load_min, load_sec;

  logic [5:0] min4, sec4, min1, sec1;
  logic       run4, done4, run1, done1;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  countdown_timer #(.TICKS_PER_SEC(4), .MAX_VAL(59)) dut4 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .pause(pause), .minute(min4), .second(sec4), .running(run4), .done(done4)
  );

  countdown_timer #(.TICKS_PER_SEC(1), .MAX_VAL(59)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .pause(pause), .minute(min1), .second(sec1), .running(run1), .done(done1)
  );

  typedef struct packed {
    logic       ld;
    logic [5:0] lm;
    logic [5:0] ls;
    logic       st;
    logic       pa;
    logic       rn;
    logic [5:0] em;
    logic [5:0] es;
    logic       er;
    logic       ed;
  } vec_t;

  vec_t tbl [0:14];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs, let one rising edge pass, leave outputs ready to sample.
  task automatic cyc(input logic ld, input logic [5:0] lm, input logic [5:0] ls,
                     input logic st, input logic pa, input logic rn);
    load = ld; load_min = lm; load_sec = ls; start = st; pause = pa; rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk4(input string name, input int m, input int s, input int r, input int d);
    chk({name, ".min"}, int'(min4), m);
    chk({name, ".sec"}, int'(sec4), s);
    chk({name, ".run"}, int'(run4), r);
    chk({name, ".done"}, int'(done4), d);
  endtask

  initial begin
    int done_cnt;
    load = 0; load_min = 0; load_sec = 0; start = 0; pause = 0; rst_n = 0;

    //              ld  lm     ls     st  pa  rn  em     es     er  ed
    tbl[0]  = '{1'b0, 6'd0,  6'd0,  1'b0,1'b0,1'b0, 6'd0, 6'd0, 1'b0,1'b0}; // reset
    tbl[1]  = '{1'b1, 6'd63, 6'd63, 1'b0,1'b0,1'b1, 6'd59,6'd59,1'b0,1'b0}; // clamp
    tbl[2]  = '{1'b1, 6'd0,  6'd0,  1'b0,1'b0,1'b1, 6'd0, 6'd0, 1'b0,1'b0};
    tbl[3]  = '{1'b0, 6'd0,  6'd0,  1'b1,1'b0,1'b1, 6'd0, 6'd0, 1'b0,1'b0}; // start at 00:00
    tbl[4]  = '{1'b0, 6'd0,  6'd0,  1'b0,1'b0,1'b1, 6'd0, 6'd0, 1'b0,1'b0};
    tbl[5]  = '{1'b1, 6'd1,  6'd0,  1'b0,1'b0,1'b1, 6'd1, 6'd0, 1'b0,1'b0};
    tbl[6]  = '{1'b0, 6'd0,  6'd0,  1'b1,1'b0,1'b1, 6'd1, 6'd0, 1'b1,1'b0};
    tbl[7]  = '{1'b0, 6'd0,  6'd0,  1'b0,1'b0,1'b1, 6'd1, 6'd0, 1'b1,1'b0};
    tbl[8]  = '{1'b1, 6'd7,  6'd8,  1'b0,1'b1,1'b1, 6'd7, 6'd8, 1'b0,1'b0}; // load beats pause
    tbl[9]  = '{1'b0, 6'd0,  6'd0,  1'b0,1'b0,1'b1, 6'd7, 6'd8, 1'b0,1'b0};
    tbl[10] = '{1'b0, 6'd0,  6'd0,  1'b0,1'b1,1'b1, 6'd7, 6'd8, 1'b0,1'b0}; // pause in IDLE
    tbl[11] = '{1'b0, 6'd0,  6'd0,  1'b1,1'b0,1'b1, 6'd7, 6'd8, 1'b1,1'b0};
    tbl[12] = '{1'b0, 6'd0,  6'd0,  1'b0,1'b1,1'b1, 6'd7, 6'd8, 1'b0,1'b0};
    tbl[13] = '{1'b0, 6'd0,  6'd0,  1'b0,1'b1,1'b1, 6'd7, 6'd8, 1'b0,1'b0}; // pause in PAUSED
    tbl[14] = '{1'b1, 6'd0,  6'd2,  1'b1,1'b0,1'b1, 6'd0, 6'd2, 1'b0,1'b0}; // load beats start

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].ld, tbl[i].lm, tbl[i].ls, tbl[i].st, tbl[i].pa, tbl[i].rn);
      chk4($sformatf("vec%0d", i), int'(tbl[i].em), int'(tbl[i].es),
           int'(tbl[i].er), int'(tbl[i].ed));
    end

    // Basic countdown 00:03 with 4 cycles per second, then start in EXPIRED.
    cyc(1'b1, 6'd0, 6'd3, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);
    chk4("cd.start", 0, 3, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      idle();
      chk4($sformatf("cd.k+%0d", i), 0, 3 - i / 4, (i < 12) ? 1 : 0, (i == 12) ? 1 : 0);
    end
    idle();
    chk4("cd.after", 0, 0, 0, 0);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);
    chk4("cd.start_expired", 0, 0, 0, 0);
    idle();
    chk4("cd.expired_hold", 0, 0, 0, 0);

    // Borrow with 1 cycle per second: 02:00 -> 01:59 -> ... -> 00:00.
    cyc(1'b1, 6'd2, 6'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);
    chk("bor.run", int'(run1), 1);
    idle();
    chk("bor.min1", int'(min1), 1);
    chk("bor.sec1", int'(sec1), 59);
    done_cnt = int'(done1);
    for (int i = 2; i <= 123; i++) begin
      idle();
      if (done1) done_cnt++;
      if (i == 60) chk("bor.60", int'(min1) * 60 + int'(sec1), 60);
      if (i == 120) begin
        chk("bor.min120", int'(min1), 0);
        chk("bor.sec120", int'(sec1), 0);
        chk("bor.done120", int'(done1), 1);
      end
    end
    chk("bor.pulses", done_cnt, 1);
    chk("bor.run_end", int'(run1), 0);

    // Pause two cycles into a second, hold, resume: remaining 2 cycles resume exactly.
    cyc(1'b1, 6'd0, 6'd5, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);
    idle();
    idle();
    cyc(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    chk4("pr.paused", 0, 5, 0, 0);
    for (int i = 0; i < 10; i++) begin
      idle();
      chk($sformatf("pr.hold%0d", i), int'(sec4), 5);
    end
    cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);
    chk4("pr.resume", 0, 5, 1, 0);
    idle();
    chk("pr.r+1", int'(sec4), 5);
    idle();
    chk("pr.r+2", int'(sec4), 4);

    // Pause on a tick edge: tick suppressed, fires first cycle after resume.
    cyc(1'b1, 6'd0, 6'd2, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);
    idle();
    idle();
    idle();
    cyc(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    chk4("pt.paused", 0, 2, 0, 0);
    idle();
    cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);
    chk4("pt.resume", 0, 2, 1, 0);
    idle();
    chk4("pt.tick", 0, 1, 1, 0);

    // Load on the expiry edge wins; no done pulse.
    cyc(1'b1, 6'd0, 6'd1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 6'd0, 6'd4, 1'b0, 1'b0, 1'b1);
    chk("le.sec", int'(sec1), 4);
    chk("le.done", int'(done1), 0);
    chk("le.run", int'(run1), 0);

    // Reset mid-run after 5 ticks of 01:30.
    cyc(1'b1, 6'd1, 6'd30, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) idle();
    chk4("rst.before", 1, 25, 1, 0);
    cyc(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    chk4("rst.after", 0, 0, 0, 0);
    idle();
    chk4("rst.stay", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
